// File: rtl/aimc_lib.sv
// Shared constants for the broadcast response collector.
package aimc_lib;

  localparam int unsigned RP_SHIFT_SIZE     = 8;
  localparam int unsigned RP_SHIFT_NUM      = 4;
  localparam int unsigned BCAST_PIPE_LENGTH = 2;
  localparam int unsigned CH_NUM            = 4;

endpackage : aimc_lib

// File: rtl/resp_ptr_skip_first_zero_enc.sv
// Lowest-zero finder over a segment, ignoring bits below a start index.
module first_zero_enc
  import aimc_lib::*;
#(
  parameter int unsigned SIZE  = RP_SHIFT_SIZE,
  parameter int unsigned PTR_W = $clog2(SIZE)
) (
  input  logic [SIZE-1:0]  arr,
  input  logic [PTR_W-1:0] start,
  output logic             found_c,
  output logic [PTR_W-1:0] idx_c
);

  logic [SIZE-1:0] cand;

  // A slot is a candidate when it is free and at or above the start index.
  always_comb begin
    cand = '0;
    for (int i = 0; i < int'(SIZE); i++) begin
      cand[i] = !arr[i] && (PTR_W'(i) >= start);
    end
  end

  // Scan downwards so the lowest candidate is the last one written.
  always_comb begin
    found_c = 1'b0;
    idx_c   = '0;
    for (int i = int'(SIZE) - 1; i >= 0; i--) begin
      if (cand[i]) begin
        found_c = 1'b1;
        idx_c   = PTR_W'(i);
      end
    end
  end

endmodule : first_zero_enc

// File: rtl/resp_ptr_skip.sv
// Per-segment push-pointer skipper: first free slot at or after resp_push_cnt.
// Define RESP_PTR_SKIP_OREG_EN to register the outputs (1-cycle latency).
module resp_ptr_skip
  import aimc_lib::*;
#(
  parameter int unsigned SIZE  = RP_SHIFT_SIZE,
  parameter int unsigned PTR_W = $clog2(SIZE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SIZE-1:0]  resp_array,
  input  logic [PTR_W-1:0] resp_push_cnt,
  output logic [PTR_W-1:0] resp_push_ptr,
  output logic             carry_out
);

  logic             found;
  logic [PTR_W-1:0] idx;
  logic [PTR_W-1:0] ptr_d;
  logic             carry_d;

  first_zero_enc #(
    .SIZE  (SIZE),
    .PTR_W (PTR_W)
  ) u_enc (
    .arr     (resp_array),
    .start   (resp_push_cnt),
    .found_c (found),
    .idx_c   (idx)
  );

  // Pointer reads 0 whenever the segment is exhausted.
  always_comb begin
    ptr_d   = '0;
    carry_d = !found;
    if (found) begin
      ptr_d = idx;
    end
  end

`ifdef RESP_PTR_SKIP_OREG_EN
  logic [PTR_W-1:0] ptr_q;
  logic             carry_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      carry_q <= carry_d;
    end
  end

  assign resp_push_ptr = ptr_q;
  assign carry_out     = carry_q;
`else
  // Zero-latency path for the parent's single-cycle push loop; clk/rst idle.
  logic unused_ok;
  assign unused_ok = &{1'b0, clk, rst};

  assign resp_push_ptr = ptr_d;
  assign carry_out     = carry_d;
`endif

endmodule : resp_ptr_skip

// File: tb/tb_resp_ptr_skip.sv
// Directed vector bench for resp_ptr_skip (both timing builds).
module tb_resp_ptr_skip;

  localparam int unsigned SIZE  = 8;
  localparam int unsigned PTR_W = 3;

  logic             clk;
  logic             rst;
  logic [SIZE-1:0]  resp_array;
  logic [PTR_W-1:0] resp_push_cnt;
  logic [PTR_W-1:0] resp_push_ptr;
  logic             carry_out;

  int n_checks;
  int n_fail;

  typedef struct {
    logic [SIZE-1:0]  arr;
    logic [PTR_W-1:0] cnt;
    logic [PTR_W-1:0] exp_ptr;
    logic             exp_carry;
  } vec_t;

  vec_t vecs[14];

  resp_ptr_skip #(.SIZE(SIZE)) dut (
    .clk           (clk),
    .rst           (rst),
    .resp_array    (resp_array),
    .resp_push_cnt (resp_push_cnt),
    .resp_push_ptr (resp_push_ptr),
    .carry_out     (carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive on the falling edge, sample 1 time unit after the next rising edge.
  task automatic apply(input logic [SIZE-1:0] arr, input logic [PTR_W-1:0] cnt,
                       input logic r);
    @(negedge clk);
    resp_array    = arr;
    resp_push_cnt = cnt;
    rst           = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst           = 1'b1;
    resp_array    = 8'b0000_0111;
    resp_push_cnt = 3'd0;

    vecs[0]  = '{8'b0000_0111, 3'd0, 3'd3, 1'b0};
    vecs[1]  = '{8'b0001_1100, 3'd2, 3'd5, 1'b0};
    vecs[2]  = '{8'b0110_1011, 3'd3, 3'd4, 1'b0};
    vecs[3]  = '{8'b0110_1011, 3'd5, 3'd7, 1'b0};
    vecs[4]  = '{8'b1111_0000, 3'd4, 3'd0, 1'b1};
    vecs[5]  = '{8'b1111_0000, 3'd3, 3'd3, 1'b0};
    vecs[6]  = '{8'hFF,        3'd0, 3'd0, 1'b1};
    vecs[7]  = '{8'h00,        3'd6, 3'd6, 1'b0};
    vecs[8]  = '{8'h7F,        3'd7, 3'd7, 1'b0};
    vecs[9]  = '{8'h80,        3'd7, 3'd0, 1'b1};
    vecs[10] = '{8'h00,        3'd0, 3'd0, 1'b0};
    vecs[11] = '{8'hFE,        3'd0, 3'd0, 1'b0};
    vecs[12] = '{8'h0F,        3'd1, 3'd4, 1'b0};
    vecs[13] = '{8'b0111_1111, 3'd0, 3'd7, 1'b0};

    // Reset state with a live input pattern applied.
    apply(8'b0000_0111, 3'd0, 1'b1);
    apply(8'b0000_0111, 3'd0, 1'b1);
`ifdef RESP_PTR_SKIP_OREG_EN
    check("reset_ptr", int'(resp_push_ptr), 0);
    check("reset_carry", int'(carry_out), 0);
`else
    check("reset_ptr", int'(resp_push_ptr), 3);
    check("reset_carry", int'(carry_out), 0);
`endif

    // Released: 3/0 appears one edge later (immediately when combinational).
    apply(8'b0000_0111, 3'd0, 1'b0);
    check("release_ptr", int'(resp_push_ptr), 3);
    check("release_carry", int'(carry_out), 0);

    foreach (vecs[i]) begin
      apply(vecs[i].arr, vecs[i].cnt, 1'b0);
      check($sformatf("vec%0d_ptr", i), int'(resp_push_ptr), int'(vecs[i].exp_ptr));
      check($sformatf("vec%0d_carry", i), int'(carry_out), int'(vecs[i].exp_carry));
    end

    // Mid-run reset pulse for one edge, then recovery.
    apply(8'b0000_0111, 3'd0, 1'b0);
    apply(8'b0000_0111, 3'd0, 1'b1);
`ifdef RESP_PTR_SKIP_OREG_EN
    check("midrst_ptr", int'(resp_push_ptr), 0);
    check("midrst_carry", int'(carry_out), 0);
`else
    check("midrst_ptr", int'(resp_push_ptr), 3);
    check("midrst_carry", int'(carry_out), 0);
`endif
    apply(8'b0000_0111, 3'd0, 1'b0);
    check("resume_ptr", int'(resp_push_ptr), 3);
    check("resume_carry", int'(carry_out), 0);

    // Reset must not clear a carry result once released.
    apply(8'hFF, 3'd2, 1'b1);
`ifdef RESP_PTR_SKIP_OREG_EN
    check("rst_over_carry", int'(carry_out), 0);
`else
    check("rst_over_carry", int'(carry_out), 1);
`endif
    apply(8'hFF, 3'd2, 1'b0);
    check("carry_after_rst", int'(carry_out), 1);
    check("ptr_after_rst", int'(resp_push_ptr), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_resp_ptr_skip
